// File: rtl/uart_tx_sequencer_if.sv
// Signal bundle between a byte requester / parity generator and the UART
// transmit sequencer.
//
// Handshake: the sequencer raises TxReady_o only while idle. A byte is
// accepted on the clk edge where TxValid_i and TxReady_o are both high; the
// requester may drop or change TxValid_i and the frame inputs after that
// edge without affecting the frame in flight.
interface uart_tx_sequencer_if #(
  parameter int DIV_W = 16
);
  logic             TxValid_i;
  logic [7:0]       TxData_i;
  logic             TxReady_o;
  logic             ParityEnable_i;
  logic             ParityMethod_i;
  logic             StopBits_i;
  logic [DIV_W-1:0] BaudDivisor_i;
  logic [7:0]       Data_o;
  logic             ParityMethod_o;
  logic             p_ParityCalTrigger_o;
  logic             ParityResult_i;
  logic             Tx_o;
  logic [4:0]       State_o;
  logic             p_TxDone_o;

  // Requester / parity generator side
  modport master (
    output TxValid_i, TxData_i, ParityEnable_i, ParityMethod_i, StopBits_i,
           BaudDivisor_i, ParityResult_i,
    input  TxReady_o, Data_o, ParityMethod_o, p_ParityCalTrigger_o, Tx_o,
           State_o, p_TxDone_o
  );

  // Sequencer side
  modport slave (
    input  TxValid_i, TxData_i, ParityEnable_i, ParityMethod_i, StopBits_i,
           BaudDivisor_i, ParityResult_i,
    output TxReady_o, Data_o, ParityMethod_o, p_ParityCalTrigger_o, Tx_o,
           State_o, p_TxDone_o
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a byte, then serialises start bit, eight
// data bits (LSB first), an optional parity bit and one or two stop bits.
// Parity itself comes from an external registered generator which is
// triggered in the first start-bit cycle and sampled at the end of the
// start bit. All outputs are registered; the state is visible one-hot.
module uart_tx_sequencer #(
  parameter int DIV_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_sequencer_if.slave bus
);

  typedef enum logic [4:0] {
    S_INTERVAL  = 5'b00001,
    S_STARTBIT  = 5'b00010,
    S_DATABITS  = 5'b00100,
    S_PARITYBIT = 5'b01000,
    S_STOPBIT   = 5'b10000
  } state_t;

  state_t           state;
  logic [7:0]       data_q;
  logic             method_q;
  logic             par_en_q;
  logic             stop2_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic             par_bit;
  logic             tx_q;
  logic             ready_q;
  logic             trig_q;
  logic             done_q;
  logic             bit_end;

  // Last cycle of the current bit time
  assign bit_end = (cnt == div_q - DIV_W'(1));

  assign bus.TxReady_o            = ready_q;
  assign bus.Data_o               = data_q;
  assign bus.ParityMethod_o       = method_q;
  assign bus.p_ParityCalTrigger_o = trig_q;
  assign bus.Tx_o                 = tx_q;
  assign bus.State_o              = state;
  assign bus.p_TxDone_o           = done_q;

  // Frame sequencer: accept, bit timing, line drive and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INTERVAL;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 8'h00;
      method_q <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      div_q    <= DIV_W'(2);
      cnt      <= '0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_INTERVAL: begin
          tx_q <= 1'b1;
          if (ready_q && bus.TxValid_i) begin
            data_q   <= bus.TxData_i;
            method_q <= bus.ParityMethod_i;
            par_en_q <= bus.ParityEnable_i;
            stop2_q  <= bus.StopBits_i;
            // A bit time shorter than two clocks is not supported
            div_q    <= (bus.BaudDivisor_i < DIV_W'(2)) ? DIV_W'(2)
                                                         : bus.BaudDivisor_i;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            trig_q   <= 1'b1;
            state    <= S_STARTBIT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_STARTBIT: begin
          if (bit_end) begin
            cnt     <= '0;
            // Generator result has been stable since the second start cycle
            par_bit <= bus.ParityResult_i;
            tx_q    <= data_q[0];
            state   <= S_DATABITS;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        S_DATABITS: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (par_en_q) begin
                tx_q  <= par_bit;
                state <= S_PARITYBIT;
              end else begin
                tx_q  <= 1'b1;
                state <= S_STOPBIT;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= data_q[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        S_PARITYBIT: begin
          if (bit_end) begin
            cnt   <= '0;
            tx_q  <= 1'b1;
            state <= S_STOPBIT;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        S_STOPBIT: begin
          if (bit_end) begin
            cnt <= '0;
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              stop_idx <= 1'b0;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
              state    <= S_INTERVAL;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b0;
          cnt     <= '0;
          state   <= S_INTERVAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a frame-level reference model predicts every
// output each cycle, a registered parity generator closes the loop, and
// directed frames pin the model against hand-computed line patterns.
module tb_uart_tx_sequencer;

  localparam int DIV_W = 16;
  localparam logic [4:0] ST_INT = 5'b00001;
  localparam logic [4:0] ST_STA = 5'b00010;
  localparam logic [4:0] ST_DAT = 5'b00100;
  localparam logic [4:0] ST_PAR = 5'b01000;
  localparam logic [4:0] ST_STO = 5'b10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sequencer_if #(.DIV_W(DIV_W)) bus ();

  uart_tx_sequencer #(.DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Registered parity generator fed by the sequencer's latched byte
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.ParityResult_i <= 1'b0;
    else if (bus.p_ParityCalTrigger_o)
      bus.ParityResult_i <= (^bus.Data_o) ^ bus.ParityMethod_o;
  end

  // ---------------- frame-level reference model ----------------
  logic        m_active;
  logic        m_ready;
  logic        m_trig;
  logic        m_done;
  logic [7:0]  m_data;
  logic        m_method;
  logic        m_par;
  logic [11:0] m_bits;
  int          m_k;
  int          m_d;
  int          m_len;

  // Line level of each bit slot of a frame, slot 0 being the start bit
  function automatic logic [11:0] build_bits(input logic [7:0] d,
                                             input logic pe, input logic pm);
    logic [11:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    if (pe) b[9] = (^d) ^ pm;
    return b;
  endfunction

  function automatic logic [4:0] slot_state(input int s, input logic pe);
    if (s == 0) return ST_STA;
    if (s <= 8) return ST_DAT;
    if (s == 9 && pe) return ST_PAR;
    return ST_STO;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_ready  <= 1'b0;
      m_trig   <= 1'b0;
      m_done   <= 1'b0;
      m_data   <= 8'h00;
      m_method <= 1'b0;
      m_par    <= 1'b0;
      m_bits   <= '1;
      m_k      <= 0;
      m_d      <= 2;
      m_len    <= 0;
    end else begin
      m_trig <= 1'b0;
      m_done <= 1'b0;
      if (m_active) begin
        if (m_k == m_len) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_ready  <= 1'b1;
        end else begin
          m_k <= m_k + 1;
        end
      end else if (m_ready && bus.TxValid_i) begin
        m_active <= 1'b1;
        m_ready  <= 1'b0;
        m_trig   <= 1'b1;
        m_k      <= 1;
        m_data   <= bus.TxData_i;
        m_method <= bus.ParityMethod_i;
        m_par    <= bus.ParityEnable_i;
        m_bits   <= build_bits(bus.TxData_i, bus.ParityEnable_i, bus.ParityMethod_i);
        m_d      <= (bus.BaudDivisor_i < 2) ? 2 : int'(bus.BaudDivisor_i);
        m_len    <= (10 + int'(bus.ParityEnable_i) + int'(bus.StopBits_i)) *
                    ((bus.BaudDivisor_i < 2) ? 2 : int'(bus.BaudDivisor_i));
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare every output against the model at the falling edge,
  // then return shortly after the rising edge to drive the next inputs.
  task automatic tick();
    logic       e_tx;
    logic [4:0] e_st;
    @(negedge clk);
    e_tx = 1'b1;
    e_st = ST_INT;
    if (m_active) begin
      e_tx = m_bits[(m_k - 1) / m_d];
      e_st = slot_state((m_k - 1) / m_d, m_par);
    end
    check("cyc_tx",     32'(bus.Tx_o), 32'(e_tx));
    check("cyc_state",  32'(bus.State_o), 32'(e_st));
    check("cyc_ready",  32'(bus.TxReady_o), 32'(m_ready));
    check("cyc_trig",   32'(bus.p_ParityCalTrigger_o), 32'(m_trig));
    check("cyc_done",   32'(bus.p_TxDone_o), 32'(m_done));
    check("cyc_data",   32'(bus.Data_o), 32'(m_data));
    check("cyc_method", 32'(bus.ParityMethod_o), 32'(m_method));
    @(posedge clk);
    #2;
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input logic [7:0] data, input logic pe,
                           input logic pm, input logic s2,
                           input logic [15:0] div, input bit scramble,
                           input bit hold_valid, input logic [7:0] next_data,
                           output logic [11:0] seen, output int done_k,
                           output int trig_cnt, output bit saw_par,
                           output logic [7:0] data_at_trig,
                           output int acc_ticks);
    int d;
    int nbits;
    int k;
    bit accepted;
    bus.TxData_i       = data;
    bus.ParityEnable_i = pe;
    bus.ParityMethod_i = pm;
    bus.StopBits_i     = s2;
    bus.BaudDivisor_i  = div;
    bus.TxValid_i      = 1'b1;
    seen = '0; done_k = 0; trig_cnt = 0; saw_par = 1'b0; data_at_trig = 8'h00;
    acc_ticks = 0;
    do begin
      tick();
      acc_ticks++;
      accepted = m_active && (m_k == 1);
    end while (!accepted && acc_ticks < 20);
    check("accept_seen", 32'(accepted), 32'd1);
    if (!accepted) begin
      bus.TxValid_i = 1'b0;
      return;
    end
    if (hold_valid) bus.TxData_i = next_data;
    else bus.TxValid_i = 1'b0;
    d = (div < 2) ? 2 : int'(div);
    nbits = 10 + int'(pe) + int'(s2);
    k = 1;
    data_at_trig = bus.Data_o;
    while (k < 400) begin
      if (bus.p_TxDone_o) begin
        done_k = k;
        break;
      end
      if (((k - 1) % d) == 0 && ((k - 1) / d) < nbits)
        seen[(k - 1) / d] = bus.Tx_o;
      trig_cnt += int'(bus.p_ParityCalTrigger_o);
      if (bus.State_o == ST_PAR) saw_par = 1'b1;
      if (scramble && k == 3) begin
        bus.TxData_i       = ~data;
        bus.BaudDivisor_i  = 16'd7;
        bus.ParityMethod_i = ~pm;
        bus.ParityEnable_i = ~pe;
        bus.StopBits_i     = ~s2;
      end
      tick();
      k++;
    end
    check("done_seen", 32'(done_k != 0), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [11:0] seen;
    int          done_k;
    int          trig_cnt;
    bit          saw_par;
    logic [7:0]  dtrig;
    int          acc;
    int          guard;

    bus.TxValid_i      = 1'b0;
    bus.TxData_i       = 8'h00;
    bus.ParityEnable_i = 1'b0;
    bus.ParityMethod_i = 1'b0;
    bus.StopBits_i     = 1'b0;
    bus.BaudDivisor_i  = 16'd4;
    #1 rst = 1'b0;
    repeat (3) tick();
    check("rst_tx",    32'(bus.Tx_o), 32'd1);
    check("rst_state", 32'(bus.State_o), 32'(ST_INT));
    check("rst_ready", 32'(bus.TxReady_o), 32'd0);
    check("rst_data",  32'(bus.Data_o), 32'h00);
    rst = 1'b1;
    check("rel_ready_before_edge", 32'(bus.TxReady_o), 32'd0);
    tick();
    check("rel_ready_first_cycle", 32'(bus.TxReady_o), 32'd1);
    repeat (2) tick();

    // 0x55, D=4, even parity, one stop
    run_frame(8'h55, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("f55_bits", 32'(seen), 32'h4AA);
    check("f55_done_cycle", 32'(done_k), 32'd45);
    repeat (3) tick();

    // 0x07, D=3, odd parity, one stop
    run_frame(8'h07, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("f07_trig_count", 32'(trig_cnt), 32'd1);
    check("f07_data_at_trig", 32'(dtrig), 32'h07);
    check("f07_parity_bit", 32'(seen[9]), 32'd0);
    check("f07_bits", 32'(seen), 32'h40E);
    check("f07_done_cycle", 32'(done_k), 32'd34);
    repeat (2) tick();

    // 0xA3, D=5, no parity, two stops
    run_frame(8'hA3, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("fA3_bits", 32'(seen), 32'h746);
    check("fA3_done_cycle", 32'(done_k), 32'd56);
    check("fA3_no_parity_state", 32'(saw_par), 32'd0);
    repeat (2) tick();

    // 0xFF, D=2, odd parity, two stops
    run_frame(8'hFF, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("fFF_bits", 32'(seen), 32'hFFE);
    check("fFF_done_cycle", 32'(done_k), 32'd25);
    repeat (2) tick();

    // Divisor 0 clamps to 2; inputs scrambled mid-frame
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("f3C_bits", 32'(seen), 32'h478);
    check("f3C_done_cycle", 32'(done_k), 32'd23);
    repeat (2) tick();

    // Back-to-back: 0x01 then 0x80 with valid held, D=2
    run_frame(8'h01, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 8'h80,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("b2b_first_done", 32'(done_k), 32'd21);
    check("b2b_gap_idle_high", 32'(bus.Tx_o), 32'd1);
    check("b2b_gap_ready", 32'(bus.TxReady_o), 32'd1);
    run_frame(8'h80, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("b2b_restart_delay", 32'(acc), 32'd1);
    check("b2b_second_data", 32'(dtrig), 32'h80);
    check("b2b_second_bits", 32'(seen), 32'h300);
    check("b2b_second_done", 32'(done_k), 32'd21);
    repeat (2) tick();

    // Reset in DATABITS aborts the frame
    bus.TxData_i       = 8'hC3;
    bus.ParityEnable_i = 1'b1;
    bus.ParityMethod_i = 1'b0;
    bus.StopBits_i     = 1'b0;
    bus.BaudDivisor_i  = 16'd4;
    bus.TxValid_i      = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(m_active && m_k == 1) && guard < 20);
    bus.TxValid_i = 1'b0;
    repeat (6) tick();
    check("abort_in_databits", 32'(bus.State_o), 32'(ST_DAT));
    #1 rst = 1'b0;
    #1;
    check("abort_tx_async", 32'(bus.Tx_o), 32'd1);
    check("abort_state_async", 32'(bus.State_o), 32'(ST_INT));
    check("abort_no_done", 32'(bus.p_TxDone_o), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    check("abort_ready_before_edge", 32'(bus.TxReady_o), 32'd0);
    tick();
    check("abort_ready_after_release", 32'(bus.TxReady_o), 32'd1);

    // Recovery frame after the aborted one
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 8'h00,
              seen, done_k, trig_cnt, saw_par, dtrig, acc);
    check("post_abort_bits", 32'(seen), 32'h2B4);
    check("post_abort_done", 32'(done_k), 32'd21);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
